// File: rtl/cvxif_copro_responder.sv
// CV-X-IF coprocessor responder: decodes custom-3 ALU ops, waits for commit/kill,
// executes over a fixed number of cycles and returns a single writeback result.
module cvxif_copro_responder #(
  parameter int XLEN     = 32,
  parameter int ID_WIDTH = 3,
  parameter int LATENCY  = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                issue_valid_i,
  output logic                issue_ready_o,
  input  logic [31:0]         issue_instr_i,
  input  logic [ID_WIDTH-1:0] issue_id_i,
  input  logic [XLEN-1:0]     issue_rs1_i,
  input  logic [XLEN-1:0]     issue_rs2_i,
  output logic                issue_accept_o,
  output logic                issue_writeback_o,
  input  logic                commit_valid_i,
  input  logic [ID_WIDTH-1:0] commit_id_i,
  input  logic                commit_kill_i,
  output logic                result_valid_o,
  input  logic                result_ready_i,
  output logic [ID_WIDTH-1:0] result_id_o,
  output logic [XLEN-1:0]     result_data_o,
  output logic [4:0]          result_rd_o,
  output logic                result_we_o
);

  localparam int SHW = $clog2(XLEN);
  localparam int CW  = 4;

  typedef enum logic [1:0] {IDLE, WAIT_COMMIT, EXEC, RESULT} state_e;
  typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_XOR, OP_ROTL} op_e;

  state_e                state_q;
  logic [CW-1:0]         cnt_q;
  logic [ID_WIDTH-1:0]   id_q;
  logic [4:0]            rd_q;
  op_e                   op_q;
  logic [XLEN-1:0]       rs1_q;
  logic [XLEN-1:0]       rs2_q;
  logic [XLEN-1:0]       res_data_q;

  logic                  dec_ok;
  op_e                   dec_op;
  logic [4:0]            dec_rd;
  logic                  take_issue;
  logic                  commit_hit;

  // NOTE: every variable written in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    dec_ok = 1'b0;
    dec_op = OP_ADD;
    dec_rd = issue_instr_i[11:7];
    if (issue_instr_i[6:0] == 7'h7B && issue_instr_i[31:25] == 7'd0 &&
        issue_instr_i[14] == 1'b0) begin
      dec_ok = 1'b1;
      dec_op = op_e'(issue_instr_i[13:12]);
    end
  end

  assign take_issue = (state_q == IDLE) && issue_valid_i && dec_ok;
  assign commit_hit = commit_valid_i && (commit_id_i == id_q);

  function automatic logic [XLEN-1:0] alu(input op_e op,
                                          input logic [XLEN-1:0] a,
                                          input logic [XLEN-1:0] b);
    logic [2*XLEN-1:0] dbl;
    logic [SHW-1:0]    sh;
    sh  = b[SHW-1:0];
    // Rotating left equals shifting the doubled word and keeping the top half.
    dbl = {a, a} << sh;
    alu = '0;
    unique case (op)
      OP_ADD:  alu = a + b;
      OP_SUB:  alu = a - b;
      OP_XOR:  alu = a ^ b;
      OP_ROTL: alu = dbl[2*XLEN-1:XLEN];
    endcase
  endfunction

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      id_q       <= '0;
      rd_q       <= '0;
      res_data_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (take_issue) begin
            id_q    <= issue_id_i;
            rd_q    <= dec_rd;
            state_q <= WAIT_COMMIT;
          end
        end
        WAIT_COMMIT: begin
          if (commit_hit) begin
            if (commit_kill_i || rd_q == 5'd0) begin
              state_q <= IDLE;
            end else if (LATENCY == 1) begin
              // Single-cycle latency has no counting phase at all.
              res_data_q <= alu(op_q, rs1_q, rs2_q);
              state_q    <= RESULT;
            end else begin
              cnt_q   <= CW'(LATENCY - 1);
              state_q <= EXEC;
            end
          end
        end
        EXEC: begin
          cnt_q <= cnt_q - 1'b1;
          // The counter reaches zero on this edge: publish the result.
          if (cnt_q == CW'(1)) begin
            res_data_q <= alu(op_q, rs1_q, rs2_q);
            state_q    <= RESULT;
          end
        end
        RESULT: begin
          if (result_ready_i) state_q <= IDLE;
        end
      endcase
    end
  end

  // NOTE: operand registers are deliberately left without reset; they are
  // always loaded on an accepted issue before anything reads them.
  always_ff @(posedge clk_i) begin
    if (take_issue) begin
      op_q  <= dec_op;
      rs1_q <= issue_rs1_i;
      rs2_q <= issue_rs2_i;
    end
  end

  // Outputs are forced low for the whole time reset is held, including the
  // first cycle before the state register has been cleared.
  assign issue_ready_o     = (state_q == IDLE) && !rst_i;
  assign issue_accept_o    = dec_ok && !rst_i;
  assign issue_writeback_o = dec_ok && (dec_rd != 5'd0) && !rst_i;
  assign result_valid_o    = (state_q == RESULT) && !rst_i;
  assign result_we_o       = result_valid_o;
  assign result_id_o       = rst_i ? '0 : id_q;
  assign result_rd_o       = rst_i ? '0 : rd_q;
  assign result_data_o     = rst_i ? '0 : res_data_q;

endmodule

// File: tb/tb_cvxif_copro_responder.sv
// Bench for cvxif_copro_responder: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a timestamp-based model.
module tb_cvxif_copro_responder;

  localparam int XLEN     = 32;
  localparam int ID_WIDTH = 3;
  localparam int LATENCY  = 2;

  logic                clk_i = 1'b0;
  logic                rst_i;
  logic                issue_valid_i;
  logic                issue_ready_o;
  logic [31:0]         issue_instr_i;
  logic [ID_WIDTH-1:0] issue_id_i;
  logic [XLEN-1:0]     issue_rs1_i;
  logic [XLEN-1:0]     issue_rs2_i;
  logic                issue_accept_o;
  logic                issue_writeback_o;
  logic                commit_valid_i;
  logic [ID_WIDTH-1:0] commit_id_i;
  logic                commit_kill_i;
  logic                result_valid_o;
  logic                result_ready_i;
  logic [ID_WIDTH-1:0] result_id_o;
  logic [XLEN-1:0]     result_data_o;
  logic [4:0]          result_rd_o;
  logic                result_we_o;

  cvxif_copro_responder #(.XLEN(XLEN), .ID_WIDTH(ID_WIDTH), .LATENCY(LATENCY)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
    .issue_instr_i(issue_instr_i), .issue_id_i(issue_id_i),
    .issue_rs1_i(issue_rs1_i), .issue_rs2_i(issue_rs2_i),
    .issue_accept_o(issue_accept_o), .issue_writeback_o(issue_writeback_o),
    .commit_valid_i(commit_valid_i), .commit_id_i(commit_id_i), .commit_kill_i(commit_kill_i),
    .result_valid_o(result_valid_o), .result_ready_i(result_ready_i),
    .result_id_o(result_id_o), .result_data_o(result_data_o),
    .result_rd_o(result_rd_o), .result_we_o(result_we_o)
  );

  always #5 clk_i = ~clk_i;

  int    checks = 0;
  int    errors = 0;
  longint cyc   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  // One instruction is tracked as: held (busy), awaiting commit, and the cycle
  // index from which its result must be visible (due).
  bit          m_busy = 1'b0;
  bit          m_wait = 1'b0;
  bit          m_wb   = 1'b0;
  logic [2:0]  m_id   = '0;
  logic [4:0]  m_rd   = '0;
  logic [31:0] m_data = '0;
  longint      m_due  = -1;

  function automatic bit ref_accept(input logic [31:0] ins);
    return ins[6:0] == 7'h7B && ins[31:25] == 7'd0 && ins[14:12] <= 3'd3;
  endfunction

  function automatic logic [31:0] ref_exec(input logic [31:0] ins, input logic [31:0] a,
                                           input logic [31:0] b);
    logic [31:0] r;
    case (ins[14:12])
      3'd0:    r = a + b;
      3'd1:    r = a - b;
      3'd2:    r = a ^ b;
      default: begin
        r = a;
        repeat (b[4:0]) r = {r[30:0], r[31]};
      end
    endcase
    return r;
  endfunction

  function automatic bit exp_valid();
    return m_due >= 0 && cyc >= m_due;
  endfunction

  initial begin
    forever begin
      @(posedge clk_i);
      if (rst_i) begin
        m_busy = 1'b0; m_wait = 1'b0; m_due = -1;
      end else if (!m_busy) begin
        if (issue_valid_i && ref_accept(issue_instr_i)) begin
          m_busy = 1'b1; m_wait = 1'b1;
          m_id   = issue_id_i;
          m_rd   = issue_instr_i[11:7];
          m_wb   = issue_instr_i[11:7] != 5'd0;
          m_data = ref_exec(issue_instr_i, issue_rs1_i, issue_rs2_i);
        end
      end else if (m_wait) begin
        if (commit_valid_i && commit_id_i == m_id) begin
          m_wait = 1'b0;
          if (commit_kill_i || !m_wb) m_busy = 1'b0;
          else m_due = cyc + LATENCY;
        end
      end else if (exp_valid() && result_ready_i) begin
        m_busy = 1'b0; m_due = -1;
      end
      cyc++;
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clk_i);
      if (rst_i) begin
        check("rst_issue_ready", 32'(issue_ready_o), 32'd0);
        check("rst_result_valid", 32'(result_valid_o), 32'd0);
        check("rst_result_data", result_data_o, 32'd0);
        check("rst_result_id", 32'(result_id_o), 32'd0);
        check("rst_result_rd", 32'(result_rd_o), 32'd0);
        check("rst_result_we", 32'(result_we_o), 32'd0);
      end else begin
        check("issue_ready", 32'(issue_ready_o), 32'(!m_busy));
        if (!m_busy && issue_valid_i) begin
          check("issue_accept", 32'(issue_accept_o), 32'(ref_accept(issue_instr_i)));
          check("issue_writeback", 32'(issue_writeback_o),
                32'(ref_accept(issue_instr_i) && issue_instr_i[11:7] != 5'd0));
        end
        check("result_valid", 32'(result_valid_o), 32'(exp_valid()));
        check("result_we", 32'(result_we_o), 32'(exp_valid()));
        if (exp_valid()) begin
          check("result_data", result_data_o, m_data);
          check("result_id", 32'(result_id_o), 32'(m_id));
          check("result_rd", 32'(result_rd_o), 32'(m_rd));
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [31:0] mk(input logic [6:0] f7, input logic [2:0] f3,
                                     input logic [4:0] rd, input logic [6:0] opc);
    return {f7, 5'd11, 5'd10, f3, rd, opc};
  endfunction

  task automatic issue(input logic [31:0] ins, input logic [2:0] id,
                       input logic [31:0] a, input logic [31:0] b);
    issue_valid_i = 1'b1; issue_instr_i = ins; issue_id_i = id;
    issue_rs1_i = a; issue_rs2_i = b;
  endtask

  task automatic commit(input logic [2:0] id, input logic kill);
    commit_valid_i = 1'b1; commit_id_i = id; commit_kill_i = kill;
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      default: return $urandom();
    endcase
  endfunction

  task automatic rand_cycle();
    int r;
    rst_i         = ($urandom_range(0, 299) == 0);
    issue_valid_i = ($urandom_range(0, 2) != 0);
    r = $urandom_range(0, 9);
    if (r < 7)
      issue_instr_i = mk(7'd0, 3'($urandom_range(0, 3)),
                         ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31)), 7'h7B);
    else if (r == 7) issue_instr_i = $urandom();
    else if (r == 8) issue_instr_i = mk(7'd0, 3'($urandom_range(4, 7)), 5'd3, 7'h7B);
    else             issue_instr_i = mk(7'($urandom_range(1, 127)), 3'd0, 5'd3, 7'h7B);
    issue_id_i     = 3'($urandom_range(0, 7));
    issue_rs1_i    = rand_operand();
    issue_rs2_i    = rand_operand();
    commit_valid_i = ($urandom_range(0, 2) == 0);
    commit_id_i    = ($urandom_range(0, 1) == 0) ? m_id : 3'($urandom_range(0, 7));
    commit_kill_i  = ($urandom_range(0, 4) == 0);
    result_ready_i = ($urandom_range(0, 2) == 0);
  endtask

  // ---------------- directed then random ----------------
  initial begin
    rst_i = 1'b1; issue_valid_i = 1'b0; issue_instr_i = '0; issue_id_i = '0;
    issue_rs1_i = '0; issue_rs2_i = '0; commit_valid_i = 1'b0; commit_id_i = '0;
    commit_kill_i = 1'b0; result_ready_i = 1'b0;
    tick(); tick();
    @(negedge clk_i);
    check("lit_rst_ready", 32'(issue_ready_o), 32'd0);
    check("lit_rst_valid", 32'(result_valid_o), 32'd0);
    tick(); rst_i = 1'b0;
    @(negedge clk_i); check("lit_idle_ready", 32'(issue_ready_o), 32'd1);

    // ADD 5+7, commit at N, result at N+2
    tick(); issue(32'h00B5057B, 3'd3, 32'd5, 32'd7);
    @(negedge clk_i);
    check("lit_add_accept", 32'(issue_accept_o), 32'd1);
    check("lit_add_wb", 32'(issue_writeback_o), 32'd1);
    tick(); issue_valid_i = 1'b0; commit(3'd3, 1'b0);
    @(negedge clk_i); check("lit_add_n0", 32'(result_valid_o), 32'd0);
    tick(); commit_valid_i = 1'b0; result_ready_i = 1'b1;
    @(negedge clk_i); check("lit_add_n1", 32'(result_valid_o), 32'd0);
    tick();
    @(negedge clk_i);
    check("lit_add_valid", 32'(result_valid_o), 32'd1);
    check("lit_add_data", result_data_o, 32'd12);
    check("lit_add_rd", 32'(result_rd_o), 32'd10);
    check("lit_add_id", 32'(result_id_o), 32'd3);
    tick(); result_ready_i = 1'b0;
    @(negedge clk_i); check("lit_add_back_idle", 32'(issue_ready_o), 32'd1);

    // Rejects, then back-to-back ADD accepted, then mismatch and kill
    issue(mk(7'd0, 3'd0, 5'd10, 7'h33), 3'd1, 32'd1, 32'd1);
    @(negedge clk_i);
    check("lit_rej_op_accept", 32'(issue_accept_o), 32'd0);
    check("lit_rej_op_wb", 32'(issue_writeback_o), 32'd0);
    tick(); issue(mk(7'd0, 3'd4, 5'd10, 7'h7B), 3'd1, 32'd1, 32'd1);
    @(negedge clk_i);
    check("lit_rej_f3_accept", 32'(issue_accept_o), 32'd0);
    check("lit_rej_ready", 32'(issue_ready_o), 32'd1);
    tick(); issue(mk(7'd0, 3'd0, 5'd5, 7'h7B), 3'd2, 32'd1, 32'd1);
    @(negedge clk_i); check("lit_b2b_accept", 32'(issue_accept_o), 32'd1);
    tick(); issue_valid_i = 1'b0; commit(3'd5, 1'b0);
    @(negedge clk_i); check("lit_mismatch_busy", 32'(issue_ready_o), 32'd0);
    tick(); commit(3'd2, 1'b1);
    @(negedge clk_i); check("lit_kill_busy", 32'(issue_ready_o), 32'd0);
    tick(); commit_valid_i = 1'b0;
    @(negedge clk_i); check("lit_kill_ready", 32'(issue_ready_o), 32'd1);
    for (int i = 0; i < 10; i++) begin
      tick();
      @(negedge clk_i); check("lit_kill_noresult", 32'(result_valid_o), 32'd0);
    end

    // SUB 0-1 under backpressure
    tick(); issue(mk(7'd0, 3'd1, 5'd7, 7'h7B), 3'd1, 32'd0, 32'd1);
    tick(); issue_valid_i = 1'b0; commit(3'd1, 1'b0);
    tick(); commit_valid_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      @(negedge clk_i);
      check("lit_sub_hold_valid", 32'(result_valid_o), 32'd1);
      check("lit_sub_hold_data", result_data_o, 32'hFFFF_FFFF);
    end
    tick(); result_ready_i = 1'b1;
    @(negedge clk_i); check("lit_sub_release", result_data_o, 32'hFFFF_FFFF);
    tick(); result_ready_i = 1'b0;
    @(negedge clk_i); check("lit_sub_done", 32'(result_valid_o), 32'd0);

    // ROTL 0x80000001 by 4
    issue(mk(7'd0, 3'd3, 5'd9, 7'h7B), 3'd4, 32'h8000_0001, 32'd4);
    tick(); issue_valid_i = 1'b0; commit(3'd4, 1'b0);
    tick(); commit_valid_i = 1'b0; result_ready_i = 1'b1;
    tick();
    @(negedge clk_i); check("lit_rotl_data", result_data_o, 32'h0000_0018);
    tick(); result_ready_i = 1'b0;

    // rd = x0: accepted but no writeback, commit returns straight to idle
    issue(mk(7'd0, 3'd0, 5'd0, 7'h7B), 3'd6, 32'd1, 32'd1);
    @(negedge clk_i);
    check("lit_rd0_accept", 32'(issue_accept_o), 32'd1);
    check("lit_rd0_wb", 32'(issue_writeback_o), 32'd0);
    tick(); issue_valid_i = 1'b0; commit(3'd6, 1'b0);
    tick(); commit_valid_i = 1'b0;
    @(negedge clk_i); check("lit_rd0_idle", 32'(issue_ready_o), 32'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      @(negedge clk_i); check("lit_rd0_noresult", 32'(result_valid_o), 32'd0);
    end

    // Reset while executing
    tick(); issue(mk(7'd0, 3'd0, 5'd3, 7'h7B), 3'd0, 32'd1, 32'd2);
    tick(); issue_valid_i = 1'b0; commit(3'd0, 1'b0);
    tick(); commit_valid_i = 1'b0; rst_i = 1'b1;
    @(negedge clk_i);
    check("lit_rst_exec_ready", 32'(issue_ready_o), 32'd0);
    check("lit_rst_exec_data", result_data_o, 32'd0);
    tick(); rst_i = 1'b0;
    @(negedge clk_i);
    check("lit_post_rst_valid", 32'(result_valid_o), 32'd0);
    check("lit_post_rst_ready", 32'(issue_ready_o), 32'd1);
    tick(); issue(mk(7'd0, 3'd0, 5'd4, 7'h7B), 3'd7, 32'd10, 32'd20);
    @(negedge clk_i); check("lit_post_rst_accept", 32'(issue_accept_o), 32'd1);
    tick(); issue_valid_i = 1'b0; commit(3'd7, 1'b0);
    tick(); commit_valid_i = 1'b0; result_ready_i = 1'b1;
    tick();
    @(negedge clk_i);
    check("lit_post_rst_data", result_data_o, 32'd30);
    check("lit_post_rst_id", 32'(result_id_o), 32'd7);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      tick();
      rand_cycle();
    end
    tick();
    rst_i = 1'b0; issue_valid_i = 1'b0; commit_valid_i = 1'b0; result_ready_i = 1'b1;
    repeat (LATENCY + 3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
